// File: rtl/mem_arbiter_rr_pkg.sv
// mem_arb_pkg: shared types and constants for the round-robin memory arbiter.
//   arb_state_t    : arbiter FSM states (IDLE -> BUSY -> ACK -> IDLE).
//   ARB_MODE_RR    : round-robin arbitration with bounded burst lock.
//   ARB_MODE_FIXED : fixed priority, lowest port index wins.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    ACK  = 2'd2
  } arb_state_t;

  localparam logic ARB_MODE_RR    = 1'b0;
  localparam logic ARB_MODE_FIXED = 1'b1;

endpackage

// File: rtl/mem_arbiter_rr_if.sv
// mem_arbiter_rr_if: request-side and memory-side bus of the arbiter.
//   req_valid/req_we/req_addr/req_wdata : packed per-port requests (port i at slice i)
//   req_ack/rdata                       : one-hot completion pulse and read data
//   grant_idx/busy                      : last granted port, transaction in flight
//   mem_sel/mem_we/mem_addr/mem_wdata   : single memory port strobe and fields
//   mem_ready/mem_rdata                 : memory completion and read data
// Modports: slave = arbiter view, master = requesters + memory view.
interface mem_arbiter_rr_if #(
  parameter int NUM_PORTS  = 9,
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32
);
  localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  logic [NUM_PORTS-1:0]            req_valid;
  logic [NUM_PORTS-1:0]            req_we;
  logic [NUM_PORTS*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_PORTS*DATA_WIDTH-1:0] req_wdata;
  logic [NUM_PORTS-1:0]            req_ack;
  logic [DATA_WIDTH-1:0]           rdata;
  logic [IDX_W-1:0]                grant_idx;
  logic                            busy;
  logic                            mem_sel;
  logic                            mem_we;
  logic [ADDR_WIDTH-1:0]           mem_addr;
  logic [DATA_WIDTH-1:0]           mem_wdata;
  logic                            mem_ready;
  logic [DATA_WIDTH-1:0]           mem_rdata;

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, mem_ready, mem_rdata,
    output req_ack, rdata, grant_idx, busy, mem_sel, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output req_valid, req_we, req_addr, req_wdata, mem_ready, mem_rdata,
    input  req_ack, rdata, grant_idx, busy, mem_sel, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/mem_arbiter_rr_rr_pick.sv
// rr_pick: combinational first-requester search.
//   req_i   : request vector
//   start_i : port where the circular scan begins (ignored when fixed_i)
//   fixed_i : 1 = scan from port 0 (fixed priority)
//   found_o : some request is set
//   idx_o   : index of the first requester found
module rr_pick #(
  parameter int NUM_PORTS = 9,
  parameter int IDX_W     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic [NUM_PORTS-1:0] req_i,
  input  logic [IDX_W-1:0]     start_i,
  input  logic                 fixed_i,
  output logic                 found_o,
  output logic [IDX_W-1:0]     idx_o
);

  logic [IDX_W-1:0] p_s;

  // Circular scan; the wrap to port 0 is an explicit compare so that a
  // non-power-of-two port count never aliases onto unused indices.
  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    p_s     = '0;
    if (fixed_i || (int'(start_i) >= NUM_PORTS)) begin
      p_s = '0;
    end else begin
      p_s = start_i;
    end
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (!found_o && req_i[p_s]) begin
        found_o = 1'b1;
        idx_o   = p_s;
      end else begin
        found_o = found_o;
      end
      if (p_s == IDX_W'(NUM_PORTS - 1)) begin
        p_s = '0;
      end else begin
        p_s = p_s + IDX_W'(1);
      end
    end
  end

endmodule

// File: rtl/mem_arbiter_rr.sv
// mem_arbiter_rr: N-port to single memory port arbiter.
//   clk  : clock
//   rst  : synchronous active-low reset
//   bus  : mem_arbiter_rr_if.slave (requests, acks, memory port)
// One transaction at a time: IDLE picks a winner and latches its fields,
// BUSY holds the memory strobe until mem_ready, ACK pulses req_ack for one cycle.
// Round-robin mode lets the last granted port keep the grant for up to
// MAX_BURST consecutive transactions; fixed mode always favours port 0.
module mem_arbiter_rr
  import mem_arb_pkg::*;
#(
  parameter int NUM_PORTS  = 9,
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BURST  = 4,
  parameter int FIXED_PRIO = 0
) (
  input logic             clk,
  input logic             rst,
  mem_arbiter_rr_if.slave bus
);

  localparam int               IDX_W      = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int               BCNT_W     = $clog2(MAX_BURST) + 1;
  localparam logic [BCNT_W-1:0] BURST_LAST = BCNT_W'(MAX_BURST - 1);
  localparam logic             MODE       = (FIXED_PRIO != 0) ? ARB_MODE_FIXED : ARB_MODE_RR;

  arb_state_t             state_q, state_d;
  logic                   mem_sel_q, mem_sel_d;
  logic                   mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0]  mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0]  mem_wdata_q, mem_wdata_d;
  logic [DATA_WIDTH-1:0]  rdata_q, rdata_d;
  logic [NUM_PORTS-1:0]   req_ack_q, req_ack_d;
  logic [IDX_W-1:0]       grant_idx_q, grant_idx_d;
  logic                   busy_q, busy_d;
  logic [IDX_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic [BCNT_W-1:0]      burst_cnt_q, burst_cnt_d;
  // grant_idx is 0 after reset without any grant having happened; this flag
  // keeps that reset value from being mistaken for an ongoing burst.
  logic                   granted_q, granted_d;

  logic                   pick_found_s;
  logic [IDX_W-1:0]       pick_idx_s;
  logic                   burst_hit_s;
  logic [IDX_W-1:0]       win_s;

  rr_pick #(
    .NUM_PORTS (NUM_PORTS),
    .IDX_W     (IDX_W)
  ) u_pick (
    .req_i   (bus.req_valid),
    .start_i (rr_ptr_q),
    .fixed_i (MODE == ARB_MODE_FIXED),
    .found_o (pick_found_s),
    .idx_o   (pick_idx_s)
  );

  // Burst continuation test and final winner.
  always_comb begin
    burst_hit_s = 1'b0;
    win_s       = pick_idx_s;
    if ((MODE == ARB_MODE_RR) && granted_q && (burst_cnt_q < BURST_LAST) &&
        bus.req_valid[grant_idx_q]) begin
      burst_hit_s = 1'b1;
      win_s       = grant_idx_q;
    end else begin
      burst_hit_s = 1'b0;
      win_s       = pick_idx_s;
    end
  end

  // FSM next state and next values of every registered output.
  always_comb begin
    state_d     = state_q;
    mem_sel_d   = mem_sel_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rdata_d     = rdata_q;
    req_ack_d   = '0;
    grant_idx_d = grant_idx_q;
    busy_d      = busy_q;
    rr_ptr_d    = rr_ptr_q;
    burst_cnt_d = burst_cnt_q;
    granted_d   = granted_q;
    case (state_q)
      IDLE: begin
        if (pick_found_s) begin
          grant_idx_d = win_s;
          mem_addr_d  = bus.req_addr[win_s*ADDR_WIDTH +: ADDR_WIDTH];
          mem_wdata_d = bus.req_wdata[win_s*DATA_WIDTH +: DATA_WIDTH];
          mem_we_d    = bus.req_we[win_s];
          mem_sel_d   = 1'b1;
          busy_d      = 1'b1;
          granted_d   = 1'b1;
          state_d     = BUSY;
          if (MODE == ARB_MODE_FIXED) begin
            rr_ptr_d    = '0;
            burst_cnt_d = '0;
          end else if (burst_hit_s) begin
            burst_cnt_d = burst_cnt_q + BCNT_W'(1);
          end else begin
            burst_cnt_d = '0;
            if (pick_idx_s == IDX_W'(NUM_PORTS - 1)) begin
              rr_ptr_d = '0;
            end else begin
              rr_ptr_d = pick_idx_s + IDX_W'(1);
            end
          end
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        if (bus.mem_ready) begin
          mem_sel_d              = 1'b0;
          req_ack_d[grant_idx_q] = 1'b1;
          state_d                = ACK;
          if (!mem_we_q) begin
            rdata_d = bus.mem_rdata;
          end else begin
            rdata_d = rdata_q;
          end
        end else begin
          state_d = BUSY;
        end
      end
      ACK: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        mem_sel_d = 1'b0;
        busy_d    = 1'b0;
        state_d   = IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any transaction in flight.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      mem_sel_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
      req_ack_q   <= '0;
      grant_idx_q <= '0;
      busy_q      <= 1'b0;
      rr_ptr_q    <= '0;
      burst_cnt_q <= '0;
      granted_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_sel_q   <= mem_sel_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rdata_q     <= rdata_d;
      req_ack_q   <= req_ack_d;
      grant_idx_q <= grant_idx_d;
      busy_q      <= busy_d;
      rr_ptr_q    <= rr_ptr_d;
      burst_cnt_q <= burst_cnt_d;
      granted_q   <= granted_d;
    end
  end

  assign bus.mem_sel   = mem_sel_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.rdata     = rdata_q;
  assign bus.req_ack   = req_ack_q;
  assign bus.grant_idx = grant_idx_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_mem_arbiter_rr.sv
// tb_mem_arbiter_rr: directed bench for mem_arbiter_rr.
// Three arbiter instances share clock and reset:
//   dut_a : round-robin, MAX_BURST=4, backed by a small memory model
//   dut_b : round-robin, MAX_BURST=1, mem_ready tied high
//   dut_c : fixed priority, mem_ready tied high
module tb_mem_arbiter_rr;

  logic clk;
  logic rst;

  mem_arbiter_rr_if #(.NUM_PORTS(9), .ADDR_WIDTH(16), .DATA_WIDTH(32)) ifa ();
  mem_arbiter_rr_if #(.NUM_PORTS(9), .ADDR_WIDTH(16), .DATA_WIDTH(32)) ifb ();
  mem_arbiter_rr_if #(.NUM_PORTS(9), .ADDR_WIDTH(16), .DATA_WIDTH(32)) ifc ();

  mem_arbiter_rr #(.NUM_PORTS(9), .ADDR_WIDTH(16), .DATA_WIDTH(32), .MAX_BURST(4), .FIXED_PRIO(0))
    dut_a (.clk(clk), .rst(rst), .bus(ifa.slave));
  mem_arbiter_rr #(.NUM_PORTS(9), .ADDR_WIDTH(16), .DATA_WIDTH(32), .MAX_BURST(1), .FIXED_PRIO(0))
    dut_b (.clk(clk), .rst(rst), .bus(ifb.slave));
  mem_arbiter_rr #(.NUM_PORTS(9), .ADDR_WIDTH(16), .DATA_WIDTH(32), .MAX_BURST(4), .FIXED_PRIO(1))
    dut_c (.clk(clk), .rst(rst), .bus(ifc.slave));

  int n_vec;
  int n_err;
  int n_ack;
  int exp3 [7]  = '{0, 4, 8, 0, 4, 8, 0};
  int exp4 [11] = '{2, 2, 2, 2, 5, 5, 5, 5, 2, 2, 5};
  int exp5 [5]  = '{1, 1, 1, 1, 6};

  logic [31:0] mem_a [0:255];

  always #5 clk = ~clk;

  // Memory model behind dut_a: combinational read, write on completion.
  assign ifa.mem_rdata = mem_a[ifa.mem_addr[7:0]];
  always @(posedge clk) begin
    if (ifa.mem_sel && ifa.mem_we && ifa.mem_ready) mem_a[ifa.mem_addr[7:0]] <= ifa.mem_wdata;
  end

  assign ifb.mem_ready = 1'b1;
  assign ifb.mem_rdata = 32'h0;
  assign ifc.mem_ready = 1'b1;
  assign ifc.mem_rdata = 32'h0;

  task automatic check_vec(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    clk   = 1'b0;
    rst   = 1'b0;
    for (int i = 0; i < 256; i++) mem_a[i] = 32'h0;
    ifa.req_valid = '0; ifa.req_we = '0; ifa.req_wdata = '0; ifa.mem_ready = 1'b0;
    ifb.req_valid = '0; ifb.req_we = '0; ifb.req_addr = '0; ifb.req_wdata = '0;
    ifc.req_valid = '0; ifc.req_we = '0; ifc.req_addr = '0; ifc.req_wdata = '0;
    for (int i = 0; i < 9; i++) ifa.req_addr[i*16 +: 16] = 16'h0100 + 16'(i);

    // Test 1: all ports requesting while reset is held low for 3 cycles.
    ifa.req_valid = 9'h1FF;
    for (int c = 0; c < 3; c++) begin
      tick();
      check_vec("t1_rst_mem_sel", ifa.mem_sel, 1'b0);
      check_vec("t1_rst_req_ack", ifa.req_ack, 9'h000);
      check_vec("t1_rst_grant", ifa.grant_idx, 4'd0);
    end
    rst = 1'b1;
    tick();
    check_vec("t1_first_sel", ifa.mem_sel, 1'b1);
    check_vec("t1_first_addr", ifa.mem_addr, 16'h0100);
    check_vec("t1_first_grant", ifa.grant_idx, 4'd0);
    check_vec("t1_busy", ifa.busy, 1'b1);
    // Requester drops before ack: arbiter still completes and acks port 0.
    ifa.req_valid = '0;
    ifa.mem_ready = 1'b1;
    tick();
    check_vec("t1_ack_after_drop", ifa.req_ack, 9'h001);
    tick();
    check_vec("t1_idle_busy", ifa.busy, 1'b0);
    check_vec("t1_ack_one_cycle", ifa.req_ack, 9'h000);

    // Test 2: port 3 write then read back through the memory model.
    ifa.req_valid[3] = 1'b1;
    ifa.req_we[3]    = 1'b1;
    ifa.req_addr[3*16 +: 16]  = 16'h0010;
    ifa.req_wdata[3*32 +: 32] = 32'hDEADBEEF;
    tick();
    check_vec("t2_wr_sel", ifa.mem_sel, 1'b1);
    check_vec("t2_wr_we", ifa.mem_we, 1'b1);
    check_vec("t2_wr_addr", ifa.mem_addr, 16'h0010);
    check_vec("t2_wr_data", ifa.mem_wdata, 32'hDEADBEEF);
    check_vec("t2_wr_grant", ifa.grant_idx, 4'd3);
    check_vec("t2_wr_noack_yet", ifa.req_ack, 9'h000);
    tick();
    check_vec("t2_wr_ack", ifa.req_ack, 9'b000001000);
    check_vec("t2_wr_sel_drop", ifa.mem_sel, 1'b0);
    ifa.req_valid = '0;
    tick();
    check_vec("t2_idle_ack", ifa.req_ack, 9'h000);
    ifa.req_valid[3] = 1'b1;
    ifa.req_we[3]    = 1'b0;
    tick();
    check_vec("t2_rd_sel", ifa.mem_sel, 1'b1);
    check_vec("t2_rd_we", ifa.mem_we, 1'b0);
    tick();
    check_vec("t2_rd_ack", ifa.req_ack, 9'b000001000);
    check_vec("t2_rd_data", ifa.rdata, 32'hDEADBEEF);
    ifa.req_valid = '0;
    tick();
    // mem_ready high with nothing in flight must not produce an ack.
    tick();
    check_vec("t2_ready_idle_ack", ifa.req_ack, 9'h000);
    check_vec("t2_ready_idle_busy", ifa.busy, 1'b0);

    // Test 3: MAX_BURST=1, ports 0,4,8 continuous, wrap 8 -> 0.
    n_ack = 0;
    ifb.req_valid = 9'h111;
    for (int c = 0; c < 40 && n_ack < 7; c++) begin
      tick();
      if (ifb.req_ack != 9'h000) begin
        check_vec("t3_grant_ack", ifb.req_ack, 64'(9'd1 << exp3[n_ack]));
        check_vec("t3_grant_idx", ifb.grant_idx, 64'(exp3[n_ack]));
        n_ack++;
      end
    end
    check_vec("t3_ack_count", n_ack, 7);
    ifb.req_valid = '0;

    // Test 5: fixed priority, ports 1 and 6; port 1 drops after 4 grants.
    n_ack = 0;
    ifc.req_valid = 9'b001000010;
    for (int c = 0; c < 40 && n_ack < 5; c++) begin
      tick();
      if (ifc.req_ack != 9'h000) begin
        check_vec("t5_grant_ack", ifc.req_ack, 64'(9'd1 << exp5[n_ack]));
        n_ack++;
        if (n_ack == 4) ifc.req_valid[1] = 1'b0;
      end
    end
    check_vec("t5_ack_count", n_ack, 5);
    ifc.req_valid = '0;

    // Fresh reset so round-robin state starts from port 0.
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;

    // Test 4: MAX_BURST=4, ports 2 and 5; port 2 drops after 2 beats of its second burst.
    n_ack = 0;
    ifa.req_valid = 9'b000100100;
    for (int c = 0; c < 60 && n_ack < 11; c++) begin
      tick();
      if (ifa.req_ack != 9'h000) begin
        check_vec("t4_grant_ack", ifa.req_ack, 64'(9'd1 << exp4[n_ack]));
        n_ack++;
        if (n_ack == 10) ifa.req_valid[2] = 1'b0;
      end
    end
    check_vec("t4_ack_count", n_ack, 11);
    ifa.req_valid = '0;
    tick();
    tick();

    // Test 6: mem_ready stuck low in BUSY, reset pulsed mid-wait.
    ifa.mem_ready = 1'b0;
    ifa.req_valid[7] = 1'b1;
    tick();
    check_vec("t6_sel", ifa.mem_sel, 1'b1);
    check_vec("t6_grant", ifa.grant_idx, 4'd7);
    for (int c = 0; c < 10; c++) begin
      tick();
      check_vec("t6_wait_sel", ifa.mem_sel, 1'b1);
      check_vec("t6_wait_noack", ifa.req_ack, 9'h000);
    end
    ifa.req_valid = 9'b010000001;
    rst = 1'b0;
    tick();
    check_vec("t6_rst_sel", ifa.mem_sel, 1'b0);
    check_vec("t6_rst_ack", ifa.req_ack, 9'h000);
    check_vec("t6_rst_busy", ifa.busy, 1'b0);
    check_vec("t6_rst_grant", ifa.grant_idx, 4'd0);
    rst = 1'b1;
    tick();
    check_vec("t6_restart_sel", ifa.mem_sel, 1'b1);
    check_vec("t6_restart_grant", ifa.grant_idx, 4'd0);
    check_vec("t6_restart_addr", ifa.mem_addr, 16'h0100);
    check_vec("t6_restart_noack", ifa.req_ack, 9'h000);
    ifa.req_valid = '0;
    ifa.mem_ready = 1'b1;
    tick();
    check_vec("t6_restart_ack", ifa.req_ack, 9'h001);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
